// File: rtl/mesh_router_inport.sv
// One 2D-mesh router input port: two polarity-tagged VC FIFOs feeding an XY route stage.
// Optional perf counters (pkt_cnt, stall_cnt) are built only when INPORT_PERF_EN is defined.

module mesh_router_vc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

module mesh_router_inport #(
    parameter int DEPTH = 4,
    parameter int HOP_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        polarity,
    input  logic        in_si,
    output logic        in_ri,
    input  logic [63:0] in_di,
    output logic [4:0]  req,
    input  logic        gnt,
    output logic [63:0] out_do
`ifdef INPORT_PERF_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] stall_cnt
`endif
);
    localparam logic [4:0] REQ_E = 5'b00001;
    localparam logic [4:0] REQ_W = 5'b00010;
    localparam logic [4:0] REQ_N = 5'b00100;
    localparam logic [4:0] REQ_S = 5'b01000;
    localparam logic [4:0] REQ_L = 5'b10000;

    logic [1:0][63:0] head;
    logic [1:0]       full, empty, push, pop;

    logic [63:0]      act_head;
    logic [HOP_W-1:0] hops_x, hops_y;

    // A full VC refuses the push even if it pops this cycle.
    for (genvar v = 0; v < 2; v++) begin : g_vc
        assign push[v] = in_si && (in_di[0] == 1'(v)) && !full[v];
        assign pop[v]  = gnt && (req != '0) && (polarity == 1'(v));

        mesh_router_vc_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[v]),
            .pop   (pop[v]),
            .din   (in_di),
            .head  (head[v]),
            .full  (full[v]),
            .empty (empty[v])
        );
    end

    assign in_ri = !full[~polarity];

    assign act_head = head[polarity];
    assign hops_x   = act_head[8 +: HOP_W];
    assign hops_y   = act_head[12 +: HOP_W];

    // XY order: exhaust x hops first; only the selected non-zero field is decremented.
    always_comb begin
        req    = '0;
        out_do = '0;
        if (!empty[polarity]) begin
            out_do    = act_head;
            out_do[0] = ~polarity;
            if (hops_x != '0) begin
                req                 = act_head[1] ? REQ_W : REQ_E;
                out_do[8 +: HOP_W]  = hops_x - HOP_W'(1);
            end else if (hops_y != '0) begin
                req                 = act_head[2] ? REQ_S : REQ_N;
                out_do[12 +: HOP_W] = hops_y - HOP_W'(1);
            end else begin
                req = REQ_L;
            end
        end
    end

`ifdef INPORT_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if ((push != '0) && (pkt_cnt != 16'hFFFF))
                pkt_cnt <= pkt_cnt + 16'd1;
            if ((req != '0) && !gnt && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule
